// File: rtl/instr_sequencer.sv
// ---------------------------------------------------------------------------
// instr_sequencer
//   Instruction fetch/execute sequencer. Fetches an opcode word and an operand
//   word from instruction memory at {pc, sel}, hands the pair to the datapath
//   with a one-cycle exec_start, waits for exec_done, then strobes pc_enable
//   to advance the PC. Supports free-running (run), single-step (step), a
//   HALT opcode left via resume, and a memory-ack timeout that parks the
//   sequencer in FAULT until reset. Every output is a flop.
//
// Ports
//   clk, reset         clock; asynchronous active-high reset
//   run, step, resume  control: run level, step pulse, resume pulse
//   pc                 current program counter
//   pc_read_enable     PC output drive enable (high during fetches)
//   pc_enable          one-cycle PC advance strobe
//   mem_req/mem_addr   instruction read request, address {pc, sel}
//   mem_ack/mem_rdata  read data valid / read data
//   opcode, operand    latched instruction words
//   exec_start         one-cycle execute strobe
//   exec_done          datapath completion (may coincide with exec_start)
//   halted, fault      status flags for HALT and FAULT states
// ---------------------------------------------------------------------------
module instr_sequencer #(
   parameter int                    DATA_WIDTH  = 16,
   parameter logic [DATA_WIDTH-1:0] HALT_OPCODE = 16'hFF00,
   parameter int                    MEM_TIMEOUT = 255
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  run,
   input  logic                  step,
   input  logic                  resume,
   input  logic [DATA_WIDTH-1:0] pc,
   output logic                  pc_read_enable,
   output logic                  pc_enable,
   output logic                  mem_req,
   output logic [DATA_WIDTH:0]   mem_addr,
   input  logic                  mem_ack,
   input  logic [DATA_WIDTH-1:0] mem_rdata,
   output logic [DATA_WIDTH-1:0] opcode,
   output logic [DATA_WIDTH-1:0] operand,
   output logic                  exec_start,
   input  logic                  exec_done,
   output logic                  halted,
   output logic                  fault
);

   // Counter just wide enough to hold MEM_TIMEOUT; 1 bit when disabled.
   localparam int            CW  = (MEM_TIMEOUT > 0) ? $clog2(MEM_TIMEOUT + 1) : 1;
   localparam logic [CW-1:0] TMO = CW'(MEM_TIMEOUT);

   typedef enum logic [2:0] {
      S_IDLE,
      S_FETCH_OP,
      S_FETCH_ARG,
      S_EXECUTE,
      S_COMMIT,
      S_HALT,
      S_FAULT
   } state_t;

   state_t        state, nstate;
   logic          step_mode, step_mode_n;
   logic [CW-1:0] tcnt, tcnt_n, tcnt_inc;
   logic          expired;
   logic          fetch_n;

   always_comb begin
      nstate      = state;
      step_mode_n = step_mode;
      tcnt_n      = '0;
      // saturating increment: a stuck counter can never wrap back under the limit
      tcnt_inc    = (tcnt == {CW{1'b1}}) ? tcnt : tcnt + CW'(1);
      expired     = (MEM_TIMEOUT != 0) && (tcnt_inc == TMO);

      case (state)
         S_IDLE: begin
            if (run || step) begin
               nstate      = S_FETCH_OP;
               // run+step together is treated as a step
               step_mode_n = step;
            end
         end
         S_FETCH_OP: begin
            // ack wins over an expiring timeout in the same cycle
            if (mem_ack) begin
               nstate = S_FETCH_ARG;
            end else begin
               tcnt_n = tcnt_inc;
               if (expired) nstate = S_FAULT;
            end
         end
         S_FETCH_ARG: begin
            if (mem_ack) begin
               nstate = (opcode == HALT_OPCODE) ? S_HALT : S_EXECUTE;
            end else begin
               tcnt_n = tcnt_inc;
               if (expired) nstate = S_FAULT;
            end
         end
         S_EXECUTE: begin
            if (exec_done) nstate = S_COMMIT;
         end
         S_COMMIT: begin
            nstate = (run && !step_mode) ? S_FETCH_OP : S_IDLE;
         end
         S_HALT: begin
            // resume goes through COMMIT so the PC steps past the halt word
            if (resume) nstate = S_COMMIT;
         end
         S_FAULT: begin
            nstate = S_FAULT;
         end
         default: nstate = S_IDLE;
      endcase

      fetch_n = (nstate == S_FETCH_OP) || (nstate == S_FETCH_ARG);
   end

   // Outputs are decoded from the next state and registered, so they line up
   // with the state they belong to.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state          <= S_IDLE;
         step_mode      <= 1'b0;
         tcnt           <= '0;
         mem_req        <= 1'b0;
         pc_read_enable <= 1'b0;
         pc_enable      <= 1'b0;
         exec_start     <= 1'b0;
         halted         <= 1'b0;
         fault          <= 1'b0;
         mem_addr       <= '0;
         opcode         <= '0;
         operand        <= '0;
      end else begin
         state          <= nstate;
         step_mode      <= step_mode_n;
         tcnt           <= tcnt_n;
         mem_req        <= fetch_n;
         pc_read_enable <= fetch_n;
         pc_enable      <= (nstate == S_COMMIT);
         exec_start     <= (nstate == S_EXECUTE) && (state != S_EXECUTE);
         halted         <= (nstate == S_HALT);
         fault          <= (nstate == S_FAULT);

         // Address is captured once on entry to each fetch and held while
         // mem_req is up; the operand reuses the PC captured for the opcode.
         if (nstate == S_FETCH_OP && state != S_FETCH_OP)
            mem_addr <= {pc, 1'b0};
         else if (nstate == S_FETCH_ARG && state != S_FETCH_ARG)
            mem_addr <= {mem_addr[DATA_WIDTH:1], 1'b1};

         if (state == S_FETCH_OP && mem_ack)  opcode  <= mem_rdata;
         if (state == S_FETCH_ARG && mem_ack) operand <= mem_rdata;
      end
   end

endmodule

// File: doc/instr_sequencer.md
INSTR_SEQUENCER -- requirements
Module: instr_sequencer

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 16, the width of PC, opcode and operand words.
REQ-002 SHALL have parameter HALT_OPCODE, default 16'hFF00, the opcode that enters HALT.
REQ-003 SHALL have parameter MEM_TIMEOUT, default 255, the maximum cycles mem_req may wait for mem_ack; 0 disables the timeout.
REQ-004 SHALL have port clk  input  1  the single clock; all state updates on its rising edge.
REQ-005 SHALL have port reset  input  1  asynchronous, active-high reset.
REQ-006 SHALL have port run  input  1  level; 1 = fetch continuously, 0 = stop at the next instruction boundary.
REQ-007 SHALL have port step  input  1  one-cycle pulse; in IDLE, executes exactly one instruction.
REQ-008 SHALL have port resume  input  1  one-cycle pulse; leaves HALT.
REQ-009 SHALL have port pc  input  DATA_WIDTH  current program counter value.
REQ-010 SHALL have port pc_read_enable  output  1  enables the PC output drive.
REQ-011 SHALL have port pc_enable  output  1  one-cycle PC advance/branch strobe.
REQ-012 SHALL have port mem_req  output  1  instruction memory read request.
REQ-013 SHALL have port mem_addr  output  DATA_WIDTH+1  word address {pc, sel}; sel 0 = opcode, 1 = operand.
REQ-014 SHALL have port mem_ack  input  1  read data valid.
REQ-015 SHALL have port mem_rdata  input  DATA_WIDTH  read data.
REQ-016 SHALL have port opcode  output  DATA_WIDTH  latched opcode, held until the next opcode fetch completes.
REQ-017 SHALL have port operand  output  DATA_WIDTH  latched operand, with the same hold rule.
REQ-018 SHALL have port exec_start  output  1  one-cycle execute strobe to the datapath.
REQ-019 SHALL have port exec_done  input  1  datapath completion; may be asserted in the same cycle as exec_start.
REQ-020 SHALL have port halted  output  1  1 while in HALT.
REQ-021 SHALL have port fault  output  1  1 while in FAULT.

Function
REQ-022 SHALL implement states IDLE, FETCH_OP, FETCH_ARG, EXECUTE, COMMIT, HALT, FAULT, with all outputs registered.
REQ-023 SHALL transition IDLE -> FETCH_OP when run=1 or step=1.
REQ-024 SHALL, in FETCH_OP, hold mem_req=1, mem_addr={pc,0} and pc_read_enable=1; when mem_ack=1, latch mem_rdata into opcode and go to FETCH_ARG.
REQ-025 SHALL, in FETCH_ARG, behave as in FETCH_OP with mem_addr={pc,1}, latching into operand; then go to HALT if opcode==HALT_OPCODE, else to EXECUTE.
REQ-026 SHALL ignore mem_ack while mem_req=0, and SHALL keep mem_addr stable while mem_req=1.
REQ-027 SHALL drop mem_req in the cycle after the edge on which mem_ack was sampled high.
REQ-028 SHALL, in EXECUTE, assert exec_start for exactly the first cycle and wait for exec_done=1, then go to COMMIT.
REQ-029 SHALL, in COMMIT, assert pc_enable for exactly one cycle, then go to FETCH_OP if run=1, else to IDLE; a step-initiated instruction SHALL always return to IDLE.
REQ-030 SHALL complete an instruction in a minimum of 4 cycles (FETCH_OP, FETCH_ARG, EXECUTE, COMMIT, each 1 cycle when ack/done are immediate).
REQ-031 SHALL, in HALT, assert halted=1 and no pc_enable; on resume, go to COMMIT so that the PC advances past the halt instruction.
REQ-032 SHALL count consecutive cycles with mem_req=1 and mem_ack=0; when the count reaches MEM_TIMEOUT (and MEM_TIMEOUT is not 0), go to FAULT, drop mem_req and set fault=1.
REQ-033 SHALL leave FAULT only on reset.
REQ-034 SHALL give ack priority over the timeout when both occur in the same cycle.
REQ-035 SHALL ignore run=0 mid-instruction; the instruction completes through COMMIT.
REQ-036 SHALL ignore step outside IDLE and resume outside HALT.
REQ-037 SHALL ignore a simultaneous run and step in IDLE as a step; the next state is FETCH_OP in both cases.
REQ-038 SHALL size the timeout counter to hold MEM_TIMEOUT and saturate rather than wrap.

Reset
REQ-039 SHALL, on reset (asynchronous, in any state including mid-handshake), immediately force state IDLE and deassert mem_req, pc_enable, pc_read_enable, exec_start, halted and fault.
REQ-040 SHALL, on reset, clear opcode, operand, mem_addr and the timeout counter to 0.
REQ-041 SHALL resume operation on the first rising clk edge after reset deasserts.

Verification
REQ-042 SHALL cover: run=1, pc=5, immediate ack returning 16'h0102 then 16'h0007, immediate exec_done -> mem_addr 10 then 11, opcode=0102, operand=0007, exec_start at cycle 3, pc_enable at cycle 4.
REQ-043 SHALL cover: ack delayed 3 cycles on the opcode fetch -> mem_req held 4 cycles with mem_addr stable, and pc_enable 3 cycles later than in REQ-042.
REQ-044 SHALL cover: opcode FF00 fetched -> halted=1 and no pc_enable for 20 cycles; resume pulse -> exactly one pc_enable, then fetching continues.
REQ-045 SHALL cover: MEM_TIMEOUT=4 with ack never returned -> fault=1 and mem_req=0 after 4 cycles; FAULT held until reset.
REQ-046 SHALL cover: step pulse in IDLE with run=0 -> exactly one exec_start and one pc_enable, then IDLE.
REQ-047 SHALL cover: reset asserted mid-FETCH_ARG -> mem_req=0 and opcode=0 without waiting for a clock edge.
